// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_CNT_W  = 9;  // holds 1..256 remaining bytes
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    WAIT,
    CSUM
  } state_t;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CSUM frames from a byte stream and writes them
// into instruction memory, holding the CPU in reset until a frame is good.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WR_WAIT = 0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WR_WAIT == 0) ? 0 : WR_WAIT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam bit WAIT_EN    = (WR_WAIT != 0);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [LEN_CNT_W-1:0]    rem_q, rem_d;
  logic [BYTE_W-1:0]       sum_q, sum_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic [WAIT_CNT_W-1:0]   wait_q, wait_d;

  logic                    ready_d, we_d, hold_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]       addr_d;
  logic [BYTE_W-1:0]       wdata_d;

  logic                    accept;
  logic                    abort;
  logic [BYTE_W-1:0]       sum_next;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      sum_q     <= '0;
      idle_q    <= '0;
      wait_q    <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      sum_q     <= sum_d;
      idle_q    <= idle_d;
      wait_q    <= wait_d;
      in_ready  <= ready_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      cpu_hold  <= hold_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    idle_d   = idle_q;
    wait_d   = wait_q;
    we_d     = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    hold_d   = cpu_hold;
    done_d   = done;
    err_d    = err;
    abort    = 1'b0;
    accept   = in_valid && in_ready;
    sum_next = csum_add(sum_q, in_data);

    // Inter-byte idle watchdog, only while a byte is expected.
    if (state_q inside {ADDR, LEN, DATA, CSUM}) begin
      if (accept) begin
        idle_d = '0;
      end else if (TIMEOUT_EN) begin
        if (idle_q == IDLE_LAST) begin
          abort  = 1'b1;
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = ADDR;
          sum_d   = '0;
          idle_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      ADDR: begin
        if (accept) begin
          ptr_d   = ADDR_W'(in_data);
          sum_d   = sum_next;
          state_d = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          rem_d   = (in_data == '0) ? LEN_CNT_W'(256) : LEN_CNT_W'(in_data);
          sum_d   = sum_next;
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - LEN_CNT_W'(1);
          sum_d   = sum_next;
          if (WAIT_EN) begin
            state_d = WAIT;
            wait_d  = WAIT_LOAD;
          end else if (rem_q == LEN_CNT_W'(1)) begin
            state_d = CSUM;
          end
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = (rem_q == '0) ? CSUM : DATA;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = IDLE;
          sum_d   = sum_next;
          if (sum_next == '0) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort only fires on a cycle with no accepted byte; cpu_hold is kept.
    if (abort) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    ready_d = (state_d != WAIT);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (no write wait / two-cycle write wait),
// a frame-level reference model checked every cycle, plus literal checks.
module tb_imem_loader;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = 8'h00, db = 8'h00;

  logic       ra, wea, holda, busya, donea, erra;
  logic       rb, web, holdb, busyb, doneb, errb;
  logic [7:0] adra, wda, adrb, wdb;

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;

  typedef struct packed { int cyc; int addr; int data; } wr_t;
  wr_t wl_a[$];
  wr_t wl_b[$];

  typedef logic [7:0] bq_t[$];
  bq_t fr;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .WR_WAIT(0), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(va), .in_data(da), .in_ready(ra),
    .mem_we(wea), .mem_addr(adra), .mem_wdata(wda), .cpu_hold(holda),
    .busy(busya), .done(donea), .err(erra)
  );

  imem_loader #(.ADDR_W(8), .WR_WAIT(2), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(vb), .in_data(db), .in_ready(rb),
    .mem_we(web), .mem_addr(adrb), .mem_wdata(wdb), .cpu_hold(holdb),
    .busy(busyb), .done(doneb), .err(errb)
  );

  // Frame-level reference: phase 0 idle, 1 addr, 2 len, 3 data, 4 csum.
  typedef struct packed {
    int phase, ptr, rem, sum, idle, wl;
    bit we;
    int waddr, wdata;
    bit hold, busy, done, err;
  } mst_t;

  mst_t ma, mb;

  function automatic mst_t mreset();
    mst_t m;
    m = '0;
    return m;
  endfunction

  function automatic mst_t mstep(mst_t s, bit v, int d, int ww);
    mst_t n;
    n = s;
    n.we = 1'b0;
    if (s.wl > 0) begin
      n.wl = s.wl - 1;
      return n;
    end
    if (s.phase == 0) begin
      if (v && d == 'hA5) begin
        n.phase = 1; n.sum = 0; n.idle = 0;
        n.done = 1'b0; n.err = 1'b0; n.hold = 1'b1; n.busy = 1'b1;
      end
      return n;
    end
    if (!v) begin
      n.idle = s.idle + 1;
      if (n.idle == TO) begin
        n.err = 1'b1; n.phase = 0; n.busy = 1'b0; n.idle = 0;
      end
      return n;
    end
    n.idle = 0;
    n.sum = (s.sum + d) % 256;
    case (s.phase)
      1: begin n.ptr = d; n.phase = 2; end
      2: begin n.rem = (d == 0) ? 256 : d; n.phase = 3; end
      3: begin
        n.we = 1'b1; n.waddr = s.ptr; n.wdata = d;
        n.ptr = (s.ptr + 1) % 256;
        n.rem = s.rem - 1;
        n.phase = (n.rem == 0) ? 4 : 3;
        n.wl = ww;
      end
      default: begin
        n.phase = 0; n.busy = 1'b0;
        if (n.sum == 0) begin n.done = 1'b1; n.hold = 1'b0; end
        else n.err = 1'b1;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst_a)
    if (rst_a) ma <= mreset(); else ma <= mstep(ma, va, int'(da), 0);

  always @(posedge clk or posedge rst_b)
    if (rst_b) mb <= mreset(); else mb <= mstep(mb, vb, int'(db), 2);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input mst_t m, input logic r,
                         input logic we, input logic [7:0] adr,
                         input logic [7:0] wd, input logic hold,
                         input logic bsy, input logic dn, input logic er);
    chk({tag, ".in_ready"}, int'(r), int'(m.wl == 0));
    chk({tag, ".mem_we"}, int'(we), int'(m.we));
    if (m.we) begin
      chk({tag, ".mem_addr"}, int'(adr), m.waddr);
      chk({tag, ".mem_wdata"}, int'(wd), m.wdata);
    end
    chk({tag, ".cpu_hold"}, int'(hold), int'(m.hold));
    chk({tag, ".busy"}, int'(bsy), int'(m.busy));
    chk({tag, ".done"}, int'(dn), int'(m.done));
    chk({tag, ".err"}, int'(er), int'(m.err));
  endtask

  // Per-cycle model comparison and write logging.
  always @(negedge clk) begin
    cmp_out("a", ma, ra, wea, adra, wda, holda, busya, donea, erra);
    cmp_out("b", mb, rb, web, adrb, wdb, holdb, busyb, doneb, errb);
    if (wea) wl_a.push_back('{cyc, int'(adra), int'(wda)});
    if (web) wl_b.push_back('{cyc, int'(adrb), int'(wdb)});
  end

  task automatic rst_chk(input string tag, input logic r, input logic we,
                         input logic [7:0] adr, input logic [7:0] wd,
                         input logic hold, input logic bsy, input logic dn,
                         input logic er);
    chk({tag, "_rst.in_ready"}, int'(r), 1);
    chk({tag, "_rst.mem_we"}, int'(we), 0);
    chk({tag, "_rst.mem_addr"}, int'(adr), 0);
    chk({tag, "_rst.mem_wdata"}, int'(wd), 0);
    chk({tag, "_rst.cpu_hold"}, int'(hold), 0);
    chk({tag, "_rst.busy"}, int'(bsy), 0);
    chk({tag, "_rst.done"}, int'(dn), 0);
    chk({tag, "_rst.err"}, int'(er), 0);
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int inst, input logic [7:0] b);
    logic r;
    bit ok = 1'b0;
    if (inst == 0) begin va = 1'b1; da = b; end
    else begin vb = 1'b1; db = b; end
    for (int t = 0; t < 50 && !ok; t++) begin
      r = (inst == 0) ? ra : rb;
      @(posedge clk);
      #1;
      ok = r;
    end
    if (!ok) chk("send_handshake", 0, 1);
  endtask

  task automatic idle(input int inst, input int n);
    if (inst == 0) va = 1'b0; else vb = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int inst, input bq_t q, input int tail);
    foreach (q[i]) send(inst, q[i]);
    idle(inst, tail);
  endtask

  task automatic chk_wr(input string name, input wr_t w, input int a, input int d);
    chk({name, ".addr"}, w.addr, a);
    chk({name, ".data"}, w.data, d);
  endtask

  initial begin
    int k;
    #1 rst_a = 1'b1; rst_b = 1'b1;
    #2;
    rst_chk("a", ra, wea, adra, wda, holda, busya, donea, erra);
    rst_chk("b", rb, web, adrb, wdb, holdb, busyb, doneb, errb);
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    idle(0, 2);

    // Good frame, back-to-back writes.
    wl_a.delete();
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(0, fr, 3);
    chk("good.count", wl_a.size(), 3);
    if (wl_a.size() == 3) begin
      chk_wr("good.w0", wl_a[0], 'h00, 'h11);
      chk_wr("good.w1", wl_a[1], 'h01, 'h22);
      chk_wr("good.w2", wl_a[2], 'h02, 'h33);
      chk("good.gap01", wl_a[1].cyc - wl_a[0].cyc, 1);
      chk("good.gap12", wl_a[2].cyc - wl_a[1].cyc, 1);
    end
    chk("good.done", int'(donea), 1);
    chk("good.err", int'(erra), 0);
    chk("good.hold", int'(holda), 0);

    // Address wrap.
    wl_a.delete();
    fr = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF9};
    send_frame(0, fr, 3);
    chk("wrap.count", wl_a.size(), 3);
    if (wl_a.size() == 3) begin
      chk_wr("wrap.w0", wl_a[0], 'hFE, 'h01);
      chk_wr("wrap.w1", wl_a[1], 'hFF, 'h02);
      chk_wr("wrap.w2", wl_a[2], 'h00, 'h03);
    end
    chk("wrap.done", int'(donea), 1);

    // Bad checksum, then recovery.
    wl_a.delete();
    fr = '{8'hA5, 8'h10, 8'h01, 8'hAA, 8'h00};
    send_frame(0, fr, 3);
    chk("bad.count", wl_a.size(), 1);
    if (wl_a.size() == 1) chk_wr("bad.w0", wl_a[0], 'h10, 'hAA);
    chk("bad.err", int'(erra), 1);
    chk("bad.done", int'(donea), 0);
    chk("bad.hold", int'(holda), 1);
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(0, fr, 3);
    chk("recover.err", int'(erra), 0);
    chk("recover.done", int'(donea), 1);
    chk("recover.hold", int'(holda), 0);

    // Leading garbage is discarded.
    wl_a.delete();
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_frame(0, fr, 20);
    chk("garbage.count", wl_a.size(), 0);
    chk("garbage.busy", int'(busya), 0);
    chk("garbage.hold", int'(holda), 0);

    // Timeout after ADDR, then a late byte.
    wl_a.delete();
    send(0, 8'hA5);
    send(0, 8'h20);
    va = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(posedge clk); #1;
      if (erra) k = i;
    end
    chk("timeout.cycles", k, 16);
    chk("timeout.busy", int'(busya), 0);
    chk("timeout.hold", int'(holda), 1);
    send(0, 8'h05);
    idle(0, 5);
    chk("late.busy", int'(busya), 0);
    chk("late.count", wl_a.size(), 0);
    chk("late.err", int'(erra), 1);

    // Write-wait instance: writes spaced by the stall.
    wl_b.delete();
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(1, fr, 4);
    chk("wait.count", wl_b.size(), 3);
    if (wl_b.size() == 3) begin
      chk_wr("wait.w2", wl_b[2], 'h02, 'h33);
      chk("wait.gap01", wl_b[1].cyc - wl_b[0].cyc, 3);
      chk("wait.gap12", wl_b[2].cyc - wl_b[1].cyc, 3);
    end
    chk("wait.done", int'(doneb), 1);

    // Asynchronous reset in the middle of DATA.
    fr = '{8'hA5, 8'h40, 8'h04, 8'h01, 8'h02};
    send_frame(1, fr, 0);
    chk("midrst.we_before", int'(web), 1);
    rst_b = 1'b1;
    #1;
    rst_chk("b_mid", rb, web, adrb, wdb, holdb, busyb, doneb, errb);
    wl_b.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b0;
    idle(1, 10);
    chk("midrst.count", wl_b.size(), 0);
    chk("midrst.busy", int'(busyb), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
